// File: rtl/i2c_master_bit_engine.sv
// I2C master bit engine: executes one bus symbol (START, STOP, data bit, ACK/NACK, read bit)
// per accepted command, with open-drain line control, clock stretching, arbitration and timeout.
module i2c_master_bit_engine #(
  parameter int QUARTER = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic [2:0] command,
  output logic       finish,
  output logic       rx_bit,
  output logic       arb_lost,
  output logic       timeout,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_START = 3'b010;
  localparam logic [2:0] CMD_STOP  = 3'b011;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam logic [CNT_W-1:0] Q_LAST  = CNT_W'(QUARTER - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit               TO_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SETUP,
    ST_RUN
  } state_t;

  state_t           state;
  logic [1:0]       phase;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [2:0]       cmd;

  logic       is_data;
  logic       drive_low;
  logic       checks_arb;
  logic [1:0] wait_phase;
  logic       waiting;
  logic       phase_end;

  // Decode of the registered command; data bits are DATA_0/1, ACK, NACK and READ_BIT.
  always_comb begin
    is_data    = cmd[2] | (cmd == CMD_READ);
    drive_low  = cmd[2] & ~cmd[0];
    checks_arb = cmd[2] & cmd[0];
    wait_phase = is_data ? P2 : P1;
    waiting    = (state == ST_RUN) && (phase == wait_phase) && (cnt == '0) && !scl_in;
    phase_end  = (cnt == Q_LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      finish   <= 1'b1;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      rx_bit   <= 1'b0;
      arb_lost <= 1'b0;
      timeout  <= 1'b0;
      phase    <= P0;
      cnt      <= '0;
      to_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (go && command != CMD_IDLE) begin
            cmd      <= command;
            state    <= ST_SETUP;
            finish   <= 1'b0;
            arb_lost <= 1'b0;
            timeout  <= 1'b0;
            cnt      <= '0;
            to_cnt   <= '0;
          end
        end

        // One cycle with the command registered before the lines move in P0.
        ST_SETUP: begin
          state <= ST_RUN;
          phase <= P0;
          cnt   <= '0;
          if (is_data) begin
            scl_oe <= 1'b1;
            sda_oe <= drive_low;
          end else if (cmd == CMD_START) begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
          end else begin
            scl_oe <= 1'b1;
            sda_oe <= 1'b1;
          end
        end

        ST_RUN: begin
          if (waiting) begin
            // Slave is stretching SCL: the phase counter holds at zero.
            if (TO_EN && to_cnt == TO_LAST) begin
              timeout <= 1'b1;
              scl_oe  <= 1'b0;
              sda_oe  <= 1'b0;
              state   <= ST_IDLE;
              finish  <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else if (!phase_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            case (phase)
              P0: begin
                phase <= P1;
                if (cmd == CMD_STOP) scl_oe <= 1'b0;
              end
              P1: begin
                if (cmd == CMD_START && !sda_in) begin
                  arb_lost <= 1'b1;
                  scl_oe   <= 1'b0;
                  sda_oe   <= 1'b0;
                  state    <= ST_IDLE;
                  finish   <= 1'b1;
                end else begin
                  phase <= P2;
                  if (is_data)               scl_oe <= 1'b0;
                  else if (cmd == CMD_START) sda_oe <= 1'b1;
                  else                       sda_oe <= 1'b0;
                end
              end
              P2: begin
                if (is_data && cmd == CMD_READ) rx_bit <= sda_in;
                if (is_data && checks_arb && !sda_in) begin
                  arb_lost <= 1'b1;
                  scl_oe   <= 1'b0;
                  sda_oe   <= 1'b0;
                  state    <= ST_IDLE;
                  finish   <= 1'b1;
                end else begin
                  phase <= P3;
                end
              end
              P3: begin
                finish <= 1'b1;
                if (cmd == CMD_STOP) begin
                  scl_oe <= 1'b0;
                  sda_oe <= 1'b0;
                  state  <= ST_IDLE;
                end else begin
                  scl_oe <= 1'b1;
                  state  <= ST_HOLD;
                end
              end
            endcase
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_bit_engine.sv
// Directed bench for i2c_master_bit_engine with wired-AND bus, a slave model and an external master.
module tb_i2c_master_bit_engine;

  localparam logic [2:0] C_IDLE  = 3'b000;
  localparam logic [2:0] C_READ  = 3'b001;
  localparam logic [2:0] C_START = 3'b010;
  localparam logic [2:0] C_STOP  = 3'b011;
  localparam logic [2:0] C_D0    = 3'b100;
  localparam logic [2:0] C_D1    = 3'b101;
  localparam logic [2:0] C_ACK   = 3'b110;
  localparam logic [2:0] C_NACK  = 3'b111;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic [2:0] command = 3'b000;
  logic       finish, rx_bit, arb_lost, timeout, scl_oe, sda_oe;
  logic       scl_in, sda_in;
  logic       slave_scl_low = 1'b0;
  logic       slave_sda_low = 1'b0;
  logic       ext_sda_low = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  assign scl_in = ~scl_oe & ~slave_scl_low;
  assign sda_in = ~sda_oe & ~slave_sda_low & ~ext_sda_low;

  i2c_master_bit_engine #(.QUARTER(4), .CNT_W(8), .TIMEOUT(32)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .command(command),
    .finish(finish), .rx_bit(rx_bit), .arb_lost(arb_lost), .timeout(timeout),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Bus condition monitor, sampled on the falling edge.
  logic mon_en = 1'b0;
  int   mon_idx = 0;
  int   falls [4];
  int   rises [4];
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_sda && !sda_in && prev_scl && scl_in) falls[mon_idx]++;
      if (!prev_sda && sda_in && prev_scl && scl_in) rises[mon_idx]++;
    end
    prev_scl = scl_in;
    prev_sda = sda_in;
  end

  typedef struct {
    logic [2:0] cmd;
    logic       sda_slave;
    logic       sda_ext;
    int         lat;
    logic       rx;
    logic       arb;
    logic       scl;
    logic       sda;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] c, output int lat);
    go = 1'b1;
    command = c;
    tick();
    go = 1'b0;
    lat = 0;
    while (!finish && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, k, t_acc, e_p0, e_rel, e_rise, e_s, e_f;
    logic [2:0] seq [4];

    vecs[0]  = '{C_START, 0, 0, 17, 0, 0, 1, 1};
    vecs[1]  = '{C_D0,    0, 0, 17, 0, 0, 1, 1};
    vecs[2]  = '{C_D1,    0, 0, 17, 0, 0, 1, 0};
    vecs[3]  = '{C_READ,  0, 0, 17, 1, 0, 1, 0};
    vecs[4]  = '{C_READ,  1, 0, 17, 0, 0, 1, 0};
    vecs[5]  = '{C_READ,  0, 0, 17, 1, 0, 1, 0};
    vecs[6]  = '{C_D0,    0, 0, 17, 1, 0, 1, 1};
    vecs[7]  = '{C_ACK,   0, 0, 17, 1, 0, 1, 1};
    vecs[8]  = '{C_NACK,  0, 0, 17, 1, 0, 1, 0};
    vecs[9]  = '{C_STOP,  0, 0, 17, 1, 0, 0, 0};
    vecs[10] = '{C_D1,    0, 1, 13, 1, 1, 0, 0};
    vecs[11] = '{C_START, 0, 0, 17, 1, 0, 1, 1};
    vecs[12] = '{C_START, 0, 1,  9, 1, 1, 0, 0};
    vecs[13] = '{C_STOP,  0, 0, 17, 1, 0, 0, 0};
    vecs[14] = '{C_START, 0, 0, 17, 1, 0, 1, 1};
    vecs[15] = '{C_NACK,  0, 1, 13, 1, 1, 0, 0};

    // Power-on reset
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_finish", finish, 1);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_bit", rx_bit, 0);
    check("rst_arb", arb_lost, 0);
    check("rst_timeout", timeout, 0);
    reset_n = 1'b1;
    tick();

    // Table-driven single commands
    for (int i = 0; i < 16; i++) begin
      slave_sda_low = vecs[i].sda_slave;
      ext_sda_low   = vecs[i].sda_ext;
      run_cmd(vecs[i].cmd, lat);
      slave_sda_low = 1'b0;
      ext_sda_low   = 1'b0;
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rx_bit", i), rx_bit, vecs[i].rx);
      check($sformatf("v%0d_arb", i), arb_lost, vecs[i].arb);
      check($sformatf("v%0d_timeout", i), timeout, 0);
      check($sformatf("v%0d_scl_oe", i), scl_oe, vecs[i].scl);
      check($sformatf("v%0d_sda_oe", i), sda_oe, vecs[i].sda);
      tick();
    end

    // Clock stretch on READ_BIT with the slave driving a 0 (rx_bit is 1 beforehand)
    slave_sda_low = 1'b1;
    go = 1'b1;
    command = C_READ;
    tick();
    go = 1'b0;
    t_acc = cyc;
    k = 0;
    while (!scl_oe && k < 100) begin tick(); k++; end
    e_p0 = cyc;
    k = 0;
    while (scl_oe && k < 100) begin tick(); k++; end
    e_rel = cyc;
    slave_scl_low = 1'b1;
    repeat (10) tick();
    slave_scl_low = 1'b0;
    e_rise = cyc;
    k = 0;
    while (rx_bit && k < 100) begin tick(); k++; end
    e_s = cyc;
    k = 0;
    while (!finish && k < 100) begin tick(); k++; end
    e_f = cyc;
    slave_sda_low = 1'b0;
    check("stretch_sample_delay", e_s - e_rise, 4);
    check("stretch_bit_length", e_f - e_p0, 26);
    check("stretch_latency", e_f - t_acc, 27);
    check("stretch_timeout", timeout, 0);
    check("stretch_rx_bit", rx_bit, 0);
    tick();

    // Stretch timeout with SCL stuck low
    go = 1'b1;
    command = C_D0;
    tick();
    go = 1'b0;
    k = 0;
    while (scl_oe && k < 100) begin tick(); k++; end
    e_rel = cyc;
    slave_scl_low = 1'b1;
    k = 0;
    while (!timeout && k < 100) begin tick(); k++; end
    check("to_wait_clocks", cyc - e_rel, 32);
    check("to_scl_oe", scl_oe, 0);
    check("to_sda_oe", sda_oe, 0);
    check("to_finish", finish, 1);
    slave_scl_low = 1'b0;
    tick();
    check("to_sticky", timeout, 1);
    go = 1'b1;
    command = C_STOP;
    tick();
    go = 1'b0;
    check("to_cleared_by_stop", timeout, 0);
    lat = 0;
    while (!finish && lat < 300) begin tick(); lat++; end
    check("to_stop_latency", lat, 17);
    tick();

    // Back-to-back with go held high
    seq[0] = C_START; seq[1] = C_D0; seq[2] = C_D1; seq[3] = C_STOP;
    for (int i = 0; i < 4; i++) begin falls[i] = 0; rises[i] = 0; end
    mon_en = 1'b1;
    go = 1'b1;
    for (int i = 0; i < 4; i++) begin
      command = seq[i];
      mon_idx = i;
      tick();
      k = 0;
      while (!finish && k < 100) begin tick(); k++; end
      check($sformatf("b2b_gap%0d", i), k, 17);
    end
    go = 1'b0;
    command = C_IDLE;
    tick();
    mon_en = 1'b0;
    check("b2b_start_sda_fall", falls[0], 1);
    check("b2b_stop_sda_rise", rises[3], 1);
    check("b2b_data_no_cond", falls[1] + rises[1] + falls[2] + rises[2], 0);
    check("b2b_final_finish", finish, 1);
    check("b2b_final_scl_oe", scl_oe, 0);
    check("b2b_final_sda_oe", sda_oe, 0);

    // IDLE command is a no-op
    go = 1'b1;
    command = C_IDLE;
    tick();
    tick();
    go = 1'b0;
    check("noop_finish", finish, 1);
    check("noop_scl_oe", scl_oe, 0);

    // Reset in the middle of DATA_0 P2
    go = 1'b1;
    command = C_D0;
    tick();
    go = 1'b0;
    repeat (10) tick();
    check("midrst_pre_sda_oe", sda_oe, 1);
    reset_n = 1'b0;
    tick();
    check("midrst_finish", finish, 1);
    check("midrst_scl_oe", scl_oe, 0);
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_arb", arb_lost, 0);
    check("midrst_timeout", timeout, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("midrst_after_finish", finish, 1);
    check("midrst_after_scl_oe", scl_oe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
